im_read_arbiter: RTL and testbench

- Shares one AXI4-lite read channel (AR + R) to instruction memory between two requesters: port 0 = instruction fetch, port 1 = load/debug reader.
- Sits between the Core's fetch and load units and the instruction-memory AXI4-lite slave.
- Allows one outstanding transaction. Routes the R beat back to the requester that owns the transaction.

---
 rtl/im_arb_pkg.sv | 18 +
 rtl/im_arb_grant.sv | 35 +++
 rtl/im_read_arbiter.sv | 150 +++++++++++++++
 tb/tb_im_read_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_arb_pkg.sv
// im_arb_pkg
//   Shared types and constants for the instruction-memory read arbiter.
//   Holds the arbiter FSM state encoding and the number of requesters.
//   Optional build macro used by the arbiter files: IM_ARB_ROUND_ROBIN_EN
//   (round-robin instead of fixed priority between the two requesters).
package im_arb_pkg;

  // Transaction phases: waiting for a requester, presenting the address to
  // memory, and waiting for the single read beat to come back.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/im_arb_grant.sv
// im_arb_grant
//   Combinational grant selection between the two AR requesters.
//   Ports:
//     i_req     - arvalid of requester 1 and requester 0 ({s1, s0})
//     i_rr_ptr  - preferred port when both request (round-robin builds only)
//     o_grant   - one-hot grant, all zero when nobody requests
//     o_idx     - index of the granted port (0 when nobody requests)
//   Macro IM_ARB_ROUND_ROBIN_EN: when defined the pointer breaks ties,
//   otherwise port 0 always wins and the pointer input is ignored.
module im_arb_grant
  import im_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_idx
);

  logic w_pickOne;

`ifdef IM_ARB_ROUND_ROBIN_EN
  // Port 1 wins when it is the only requester, or when both request and
  // the pointer prefers it.
  assign w_pickOne = i_req[1] & (~i_req[0] | i_rr_ptr);
`else
  // Fixed priority: port 1 only wins when port 0 is silent.
  logic w_unused_ptr;
  assign w_unused_ptr = i_rr_ptr;
  assign w_pickOne    = i_req[1] & ~i_req[0];
`endif

  assign o_idx   = w_pickOne;
  assign o_grant = {w_pickOne, i_req[0] & ~w_pickOne};

endmodule

// File: rtl/im_read_arbiter.sv
// im_read_arbiter
//   Shares one AXI4-lite read channel (AR + R) to instruction memory between
//   port 0 (instruction fetch) and port 1 (load/debug reader). One
//   transaction is outstanding at a time; the R beat is routed back to the
//   requester that owns it.
//   Ports:
//     clk, rstn                  - clock, asynchronous active-low reset
//     s0_* / s1_*                - requester-side AR and R channels
//     m_*                        - memory-side AR and R channels
//     o_busy                     - a transaction is in flight
//     o_owner                    - current or last granted requester
//   Macro IM_ARB_ROUND_ROBIN_EN: enables round-robin tie breaking with a
//   1-bit pointer; without it port 0 has fixed priority.
module im_read_arbiter
  import im_arb_pkg::*;
#(
  parameter int ADDRLEN = 32,
  parameter int DATALEN = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s0_arvalid,
  output logic               s0_arready,
  input  logic [ADDRLEN-1:0] s0_araddr,
  output logic               s0_rvalid,
  input  logic               s0_rready,
  output logic [DATALEN-1:0] s0_rdata,
  input  logic               s1_arvalid,
  output logic               s1_arready,
  input  logic [ADDRLEN-1:0] s1_araddr,
  output logic               s1_rvalid,
  input  logic               s1_rready,
  output logic [DATALEN-1:0] s1_rdata,
  output logic               m_arvalid,
  input  logic               m_arready,
  output logic [ADDRLEN-1:0] m_araddr,
  input  logic               m_rvalid,
  output logic               m_rready,
  input  logic [DATALEN-1:0] m_rdata,
  output logic               o_busy,
  output logic               o_owner
);

  arb_state_e          r_state;
  arb_state_e          w_nextState;
  logic [ADDRLEN-1:0]  r_addr;
  logic                r_owner;
  logic                w_rrPtr;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grantIdx;
  logic                w_idle;
  logic                w_arHandshake;
  logic                w_ownerRready;

  // Requests are only accepted in IDLE; reset is folded in so no arready
  // can leak out while the block is held in reset.
  assign w_idle        = (r_state == ARB_IDLE) && rstn;
  assign w_arHandshake = w_idle && (w_grant != '0);
  assign w_ownerRready = r_owner ? s1_rready : s0_rready;

  im_arb_grant u_grant (
    .i_req    ({s1_arvalid, s0_arvalid}),
    .i_rr_ptr (w_rrPtr),
    .o_grant  (w_grant),
    .o_idx    (w_grantIdx)
  );

`ifdef IM_ARB_ROUND_ROBIN_EN
  logic r_rrPtr;

  // The pointer prefers whichever port was not granted last time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rrPtr <= 1'b0;
    end else if (w_arHandshake) begin
      r_rrPtr <= ~w_grantIdx;
    end
  end

  assign w_rrPtr = r_rrPtr;
`else
  assign w_rrPtr = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Address and owner are captured at the requester handshake so the
  // memory side sees a stable address for the whole ADDR phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_owner <= 1'b0;
    end else if (w_arHandshake) begin
      r_addr  <= w_grantIdx ? s1_araddr : s0_araddr;
      r_owner <= w_grantIdx;
    end
  end

  // Next state and handshake outputs. The R path is purely combinational
  // and only open in DATA, so stray memory beats elsewhere are ignored.
  always_comb begin
    w_nextState = r_state;
    s0_arready  = 1'b0;
    s1_arready  = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    s0_rvalid   = 1'b0;
    s1_rvalid   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        s0_arready = w_idle && w_grant[0];
        s1_arready = w_idle && w_grant[1];
        if (w_arHandshake) begin
          w_nextState = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          w_nextState = ARB_DATA;
        end
      end
      ARB_DATA: begin
        m_rready  = w_ownerRready;
        s0_rvalid = m_rvalid && !r_owner;
        s1_rvalid = m_rvalid && r_owner;
        if (m_rvalid && w_ownerRready) begin
          w_nextState = ARB_IDLE;
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase
  end

  assign m_araddr = r_addr;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign o_busy   = (r_state != ARB_IDLE);
  assign o_owner  = r_owner;

endmodule

// File: tb/tb_im_read_arbiter.sv
// tb_im_read_arbiter
//   Self-checking bench for im_read_arbiter. The bench plays both requesters
//   and the memory slave, and predicts grant order from a small model of the
//   arbitration policy (fixed priority, or round-robin when
//   IM_ARB_ROUND_ROBIN_EN is defined).
module tb_im_read_arbiter;

  localparam int ADDRLEN = 32;
  localparam int DATALEN = 32;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic               s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [ADDRLEN-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [DATALEN-1:0] s0_rdata, s1_rdata, m_rdata;
  logic               m_arvalid, m_arready, m_rvalid, m_rready;
  logic               o_busy, o_owner;

  int checks = 0;
  int errors = 0;
  int modelPref = 0;

  always #5 clk = ~clk;

  im_read_arbiter #(.ADDRLEN(ADDRLEN), .DATALEN(DATALEN)) dut (
    .clk(clk), .rstn(rstn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  // Policy model: who should win given the set of pending requesters.
  function automatic int pickWinner(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef IM_ARB_ROUND_ROBIN_EN
      return modelPref;
`else
      return 0;
`endif
    end
    return (r1 && !r0) ? 1 : 0;
  endfunction

  // After a grant the other port becomes the preferred one.
  task automatic noteGrant(input int p);
    modelPref = 1 - p;
  endtask

  task automatic idleInputs();
    s0_arvalid = 0; s1_arvalid = 0; s0_araddr = '0; s1_araddr = '0;
    s0_rready = 0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rstn = 0;
    #3;
    rstn = 1;
    modelPref = 0;
    @(posedge clk); #1;
  endtask

  task automatic setReq(input int p, input logic [ADDRLEN-1:0] a);
    if (p == 0) begin s0_arvalid = 1; s0_araddr = a; end
    else begin s1_arvalid = 1; s1_araddr = a; end
  endtask

  // Walk one full transaction for port p, starting in IDLE with its request
  // already driven. Memory stalls arDly cycles on AR, withholds rvalid rvDly
  // cycles, and the owner withholds rready rrDly cycles. With lateReq set,
  // port 1 raises a request at 0x400 as soon as DATA starts.
  task automatic run_txn(input int p, input logic [ADDRLEN-1:0] a,
                         input logic [DATALEN-1:0] d, input int arDly,
                         input int rvDly, input int rrDly, input bit lateReq,
                         input string tag);
    logic [1:0] expSel;
    expSel = (p == 0) ? 2'b01 : 2'b10;
    #1;
    checks++;
    if ({s1_arready, s0_arready, m_arvalid, o_busy} !== {expSel, 2'b00}) begin
      errors++;
      $display("[TB] FAIL %s grant: got arready{s1,s0}=%b%b m_arvalid=%b busy=%b, want arready=%b m_arvalid=0 busy=0",
               tag, s1_arready, s0_arready, m_arvalid, o_busy, expSel);
    end
    @(posedge clk); #1;
    if (p == 0) s0_arvalid = 0; else s1_arvalid = 0;
    noteGrant(p);
    #1;
    for (int i = 0; i <= arDly; i++) begin
      m_arready = (i == arDly);
      #1;
      checks++;
      if ({m_arvalid, m_araddr, o_owner, o_busy, s0_arready, s1_arready} !== {1'b1, a, p[0], 1'b1, 2'b00}) begin
        errors++;
        $display("[TB] FAIL %s addr phase %0d: got m_arvalid=%b m_araddr=%h owner=%b busy=%b arready=%b%b, want 1 %h %0d 1 00",
                 tag, i, m_arvalid, m_araddr, o_owner, o_busy, s1_arready, s0_arready, a, p);
      end
      @(posedge clk); #1;
    end
    m_arready = 0;
    m_rdata = d;
    if (lateReq) setReq(1, 32'h0000_0400);
    // Non-owner rready is held high to show it never leaks into m_rready.
    if (p == 0) s1_rready = 1; else s0_rready = 1;
    for (int i = 0; i < rvDly; i++) begin
      if (p == 0) s0_rready = 1; else s1_rready = 1;
      m_rvalid = 0;
      #1;
      checks++;
      if ({s1_rvalid, s0_rvalid, m_arvalid, m_rready, o_busy, s1_arready, s0_arready} !== 7'b0000_1_1_0_0 + 7'b0) begin
        errors++;
        $display("[TB] FAIL %s data wait %0d: got rvalid=%b%b m_arvalid=%b m_rready=%b busy=%b arready=%b%b, want 00 0 1 1 00",
                 tag, i, s1_rvalid, s0_rvalid, m_arvalid, m_rready, o_busy, s1_arready, s0_arready);
      end
      @(posedge clk); #1;
    end
    m_rvalid = 1;
    for (int i = 0; i <= rrDly; i++) begin
      if (p == 0) s0_rready = (i == rrDly); else s1_rready = (i == rrDly);
      #1;
      checks++;
      if ({s1_rvalid, s0_rvalid, m_rready, s0_rdata, s1_rdata, s1_arready, s0_arready} !==
          {expSel, (i == rrDly), d, d, 2'b00}) begin
        errors++;
        $display("[TB] FAIL %s R beat %0d: got rvalid=%b%b m_rready=%b rdata0=%h rdata1=%h arready=%b%b, want rvalid=%b m_rready=%b rdata=%h arready=00",
                 tag, i, s1_rvalid, s0_rvalid, m_rready, s0_rdata, s1_rdata, s1_arready, s0_arready, expSel, (i == rrDly), d);
      end
      @(posedge clk); #1;
    end
    m_rvalid = 0; s0_rready = 0; s1_rready = 0;
    #1;
    checks++;
    if ({o_busy, o_owner, m_arvalid, s1_rvalid, s0_rvalid} !== {1'b0, p[0], 3'b000}) begin
      errors++;
      $display("[TB] FAIL %s back to idle: got busy=%b owner=%b m_arvalid=%b rvalid=%b%b, want busy=0 owner=%0d 0 00",
               tag, o_busy, o_owner, m_arvalid, s1_rvalid, s0_rvalid, p);
    end
  endtask

  // Reset values, with a request and a stray beat present to prove gating.
  task automatic test_reset();
    idleInputs();
    rstn = 0;
    s0_arvalid = 1; s0_araddr = 32'hDEAD_BEE0; m_rvalid = 1; s0_rready = 1;
    #12;
    checks++;
    if ({s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, o_busy, o_owner, m_araddr} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset values: got arready=%b%b rvalid=%b%b m_arvalid=%b m_rready=%b busy=%b owner=%b m_araddr=%h, want all 0",
               s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, o_busy, o_owner, m_araddr);
    end
    idleInputs();
    @(negedge clk);
    rstn = 1;
    modelPref = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    setReq(0, 32'h0000_0010);
    run_txn(0, 32'h0000_0010, 32'h0051_3093, 0, 0, 0, 1'b0, "single");
  endtask

  // Both ports request together; repeated to exercise the pointer.
  task automatic test_both_request();
    int reps;
    int w;
    logic [ADDRLEN-1:0] addrs [2];
    addrs[0] = 32'h0000_0020;
    addrs[1] = 32'h0000_0400;
`ifdef IM_ARB_ROUND_ROBIN_EN
    reps = 3;
`else
    reps = 1;
`endif
    doReset();
    for (int r = 0; r < reps; r++) begin
      setReq(0, addrs[0]);
      setReq(1, addrs[1]);
      for (int k = 0; k < 2; k++) begin
        w = pickWinner(s0_arvalid, s1_arvalid);
        run_txn(w, addrs[w], 32'hC0DE_0000 + 32'(r * 2 + k), 0, 0, 0, 1'b0, "both");
      end
    end
  endtask

  task automatic test_backpressure();
    setReq(0, 32'h0000_0044);
    run_txn(0, 32'h0000_0044, 32'h1234_5678, 4, 0, 3, 1'b0, "backpressure");
  endtask

  task automatic test_request_during_data();
    setReq(0, 32'h0000_0080);
    run_txn(0, 32'h0000_0080, 32'hAAAA_5555, 0, 2, 1, 1'b1, "during_data_p0");
    run_txn(1, 32'h0000_0400, 32'h5555_AAAA, 1, 0, 0, 1'b0, "during_data_p1");
  endtask

  task automatic test_reset_mid_op();
    setReq(1, 32'h0000_0050);
    #1;
    @(posedge clk); #1;
    s1_arvalid = 0;
    #1;
    checks++;
    if ({o_busy, m_arvalid, o_owner} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_mid_op setup: got busy=%b m_arvalid=%b owner=%b, want 111", o_busy, m_arvalid, o_owner);
    end
    rstn = 0;
    s0_arvalid = 1;
    #1;
    checks++;
    if ({s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, o_busy, o_owner, m_araddr} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op outputs: got arready=%b%b rvalid=%b%b m_arvalid=%b m_rready=%b busy=%b owner=%b m_araddr=%h, want all 0",
               s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, o_busy, o_owner, m_araddr);
    end
    s0_arvalid = 0;
    @(negedge clk);
    rstn = 1;
    modelPref = 0;
    @(posedge clk); #1;
    setReq(0, 32'h0000_0030);
    run_txn(0, 32'h0000_0030, 32'h0BAD_F00D, 0, 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_stray_rvalid();
    m_rvalid = 1; m_rdata = 32'hFFFF_FFFF; s0_rready = 1; s1_rready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({m_rready, s0_rvalid, s1_rvalid, o_busy} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL stray rvalid %0d: got m_rready=%b rvalid=%b%b busy=%b, want 0000",
                 i, m_rready, s1_rvalid, s0_rvalid, o_busy);
      end
      @(posedge clk); #1;
    end
    m_rvalid = 0; s0_rready = 0; s1_rready = 0;
  endtask

  // Random mix of single and overlapping requests with random stalls.
  task automatic test_random();
    int w;
    logic [DATALEN-1:0] d;
    for (int r = 0; r < 40; r++) begin
      if (!s0_arvalid && ($urandom_range(0, 1) == 1)) setReq(0, $urandom & 32'hFFFF_FFFC);
      if (!s1_arvalid && ($urandom_range(0, 1) == 1)) setReq(1, $urandom & 32'hFFFF_FFFC);
      if (!s0_arvalid && !s1_arvalid) setReq(int'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      w = pickWinner(s0_arvalid, s1_arvalid);
      d = $urandom;
      run_txn(w, (w == 0) ? s0_araddr : s1_araddr, d, $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    test_reset();
    test_single_fetch();
    test_both_request();
    test_backpressure();
    test_request_during_data();
    test_reset_mid_op();
    test_stray_rvalid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
